// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
// Multicycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi, j).
// A single memory port is shared between instruction fetch and data access.
// Every access uses a req/ready handshake, so any number of wait states is
// tolerated. Unknown opcodes or functs park the core in an absorbing TRAP
// state, which can only be left through reset.
//
// Parameters
//   WIDTH     datapath / register / address width (>= 32)
//   RESET_PC  PC loaded on reset (multiple of 4)
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   mem_req_o    memory access request (FETCH, MEMRD, MEMWR only)
//   mem_we_o     1 = write, 0 = read, valid while mem_req_o = 1
//   mem_addr_o   byte address (pc in FETCH, ALUOut for data access)
//   mem_wdata_o  store data (B register)
//   mem_ready_i  access completes when mem_req_o & mem_ready_i
//   mem_rdata_i  read data, sampled only in the handshake cycle
//   retire_o     one-cycle pulse in the final cycle of each instruction
//   halted_o     high while in TRAP
//   pc_o         current PC register
// -----------------------------------------------------------------------------
module multicycle_core #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             reset_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   input  logic             mem_ready_i,
   input  logic [WIDTH-1:0] mem_rdata_i,
   output logic             retire_o,
   output logic             halted_o,
   output logic [WIDTH-1:0] pc_o
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [31:0]      ir_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] aluout_q;
   logic [WIDTH-1:0] mdr_q;
   logic [WIDTH-1:0] rf_q [32];

   logic [5:0]       opcode_d;
   logic [5:0]       funct_d;
   logic [4:0]       rs_d;
   logic [4:0]       rt_d;
   logic [4:0]       rd_d;
   logic [WIDTH-1:0] signimm_d;
   logic [WIDTH-1:0] rs_val_d;
   logic [WIDTH-1:0] rt_val_d;
   logic             rf_we_d;
   logic [4:0]       rf_waddr_d;
   logic [WIDTH-1:0] rf_wdata_d;

   // True for the R-type functs the core implements.
   function automatic logic funct_legal(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
         default:                               funct_legal = 1'b0;
      endcase
   endfunction

   // R-type ALU; arithmetic wraps, slt is a signed compare.
   function automatic logic [WIDTH-1:0] alu_op(input logic [5:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      case (f)
         FN_ADD:  alu_op = x + y;
         FN_SUB:  alu_op = x - y;
         FN_AND:  alu_op = x & y;
         FN_OR:   alu_op = x | y;
         FN_SLT:  alu_op = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         default: alu_op = {WIDTH{1'b0}};
      endcase
   endfunction

   assign opcode_d  = ir_q[31:26];
   assign funct_d   = ir_q[5:0];
   assign rs_d      = ir_q[25:21];
   assign rt_d      = ir_q[20:16];
   assign rd_d      = ir_q[15:11];
   assign signimm_d = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
   assign rs_val_d  = (rs_d == 5'd0) ? {WIDTH{1'b0}} : rf_q[rs_d];
   assign rt_val_d  = (rt_d == 5'd0) ? {WIDTH{1'b0}} : rf_q[rt_d];

   // Register-file write port selection for the three write-back states.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = 5'd0;
      rf_wdata_d = aluout_q;
      case (state_q)
         S_MEMWB: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rt_d;
            rf_wdata_d = mdr_q;
         end
         S_ALUWB: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_d;
         end
         S_ADDIWB: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rt_d;
         end
         default: begin
            rf_we_d    = 1'b0;
         end
      endcase
   end

   // Register file: cleared on reset, r0 never written.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= {WIDTH{1'b0}};
         end
      end else if (rf_we_d && (rf_waddr_d != 5'd0)) begin
         rf_q[rf_waddr_d] <= rf_wdata_d;
      end
   end

   // Controller FSM and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= 32'd0;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         aluout_q <= {WIDTH{1'b0}};
         mdr_q    <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready_i) begin
                  ir_q    <= mem_rdata_i[31:0];
                  pc_q    <= pc_q + PC_STEP;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q      <= rs_val_d;
               b_q      <= rt_val_d;
               // Branch target precomputed while the operands are read.
               aluout_q <= pc_q + {signimm_d[WIDTH-3:0], 2'b00};
               case (opcode_d)
                  OP_LW, OP_SW: state_q <= S_MEMADR;
                  OP_RTYPE:     state_q <= funct_legal(funct_d) ? S_EXEC : S_TRAP;
                  OP_BEQ:       state_q <= S_BRANCH;
                  OP_ADDI:      state_q <= S_ADDIEX;
                  OP_J:         state_q <= S_JUMP;
                  default:      state_q <= S_TRAP;
               endcase
            end
            S_MEMADR: begin
               aluout_q <= a_q + signimm_d;
               state_q  <= (opcode_d == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               if (mem_ready_i) begin
                  mdr_q   <= mem_rdata_i;
                  state_q <= S_MEMWB;
               end
            end
            S_MEMWB:  state_q <= S_FETCH;
            S_MEMWR: begin
               if (mem_ready_i) begin
                  state_q <= S_FETCH;
               end
            end
            S_EXEC: begin
               aluout_q <= alu_op(funct_d, a_q, b_q);
               state_q  <= S_ALUWB;
            end
            S_ALUWB:  state_q <= S_FETCH;
            S_ADDIEX: begin
               aluout_q <= a_q + signimm_d;
               state_q  <= S_ADDIWB;
            end
            S_ADDIWB: state_q <= S_FETCH;
            S_BRANCH: begin
               if (a_q == b_q) begin
                  pc_q <= aluout_q;
               end
               state_q <= S_FETCH;
            end
            S_JUMP: begin
               pc_q    <= {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
               state_q <= S_FETCH;
            end
            S_TRAP:   state_q <= S_TRAP;
            default:  state_q <= S_TRAP;
         endcase
      end
   end

   assign pc_o        = pc_q;
   assign mem_wdata_o = b_q;
   assign mem_addr_o  = (state_q == S_FETCH) ? pc_q : aluout_q;

   // Status/handshake decode from state; reset forces every strobe low so
   // an access pending at reset is abandoned and no retire is reported.
   always_comb begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      retire_o  = 1'b0;
      halted_o  = 1'b0;
      if (!reset_i) begin
         case (state_q)
            S_FETCH, S_MEMRD: mem_req_o = 1'b1;
            S_MEMWR: begin
               mem_req_o = 1'b1;
               mem_we_o  = 1'b1;
               retire_o  = mem_ready_i;
            end
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_o = 1'b1;
            S_TRAP:   halted_o = 1'b1;
            default:  mem_req_o = 1'b0;
         endcase
      end else begin
         mem_req_o = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle successor to the single-cycle MIPS-subset datapath. It integrates datapath and FSM controller and shares one memory port between instruction fetch and data access. The memory port uses a req/ready handshake, so the core tolerates any number of wait states. It sits between the system memory and the top-level test harness, and exposes retire and trap status for verification.

## Interface
- WIDTH, 32: datapath/register/address width; must be ≥ 32. Instructions are always 32 bits, taken from mem_rdata[31:0].
- RESET_PC, 0: PC value loaded on reset; must be a multiple of 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  WIDTH  byte address.
- mem_wdata  out  WIDTH  store data.
- mem_ready  in  1  access completes in any cycle where mem_req & mem_ready.
- mem_rdata  in  WIDTH  read data; valid when mem_ready = 1.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high in TRAP state.
- pc  out  WIDTH  current PC register.

## Operation
- ISA: R-type (op 000000; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Fields: rs = instr[25:21], rt = [20:16], rd = [15:11]. imm16 is sign-extended to WIDTH.
- Register file: 32×WIDTH, two read ports and one write port. r0 reads 0 and ignores writes. All registers clear to 0 on reset.
- Arithmetic wraps modulo 2^WIDTH with no overflow trap. slt is a signed compare, result 1 or 0.
- Internal registers: IR (32), A, B, ALUOut, MDR (WIDTH).
- FSM states and transitions:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On handshake: IR ← rdata[31:0], pc ← pc+4 → DECODE. Otherwise stay.
  - DECODE: A ← rf[rs], B ← rf[rt], ALUOut ← pc + (signimm<<2). pc is already pc+4 here.
    - lw/sw → MEMADR
    - R-type with legal funct → EXEC
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - anything else → TRAP
  - MEMADR: ALUOut ← A + signimm. lw → MEMRD, sw → MEMWR.
  - MEMRD: read handshake at ALUOut. MDR ← rdata → MEMWB.
  - MEMWB: rf[rt] ← MDR, retire → FETCH.
  - MEMWR: write handshake at ALUOut, wdata = B. On handshake: retire → FETCH.
  - EXEC: ALUOut ← A op B → ALUWB.
  - ALUWB: rf[rd] ← ALUOut, retire → FETCH.
  - ADDIEX: ALUOut ← A + signimm → ADDIWB.
  - ADDIWB: rf[rt] ← ALUOut, retire → FETCH.
  - BRANCH: if A == B then pc ← ALUOut. retire → FETCH.
  - JUMP: pc ← {pc[WIDTH-1:28], IR[25:0], 2'b00}, retire → FETCH.
  - TRAP: absorbing state; halted = 1, mem_req = 0. Leaves only on reset.
- mem_req is high only in FETCH, MEMRD and MEMWR. In those states mem_addr, mem_we and mem_wdata are held stable until the handshake completes.

## Timing
- Reset values: pc = RESET_PC, state = FETCH, mem_req = 0, mem_we = 0, retire = 0, halted = 0. IR, A, B, ALUOut and MDR are 0.
- mem_req is forced to 0 in every cycle reset is high. The first fetch request appears in the first cycle after reset deasserts.
- Reset during a pending access abandons it. No register or PC update occurs from an abandoned access.
- Cycle counts with zero-wait memory (mem_ready already high): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- retire is asserted in the final cycle of an instruction; the next cycle is FETCH.
- mem_rdata is sampled only in the handshake cycle. mem_ready while mem_req = 0 is ignored.

## Test plan
- Reset/fetch: hold reset 2 cycles with RESET_PC = 0. → mem_req = 0 during reset. First cycle after release: mem_req = 1, mem_addr = 0, mem_we = 0.
- ALU sequence: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sub r5,r2,r1. → r3 = 2, r4 = 1, r5 = 0xFFFFFFF8. Each instruction takes 4 cycles and pulses retire once.
- Memory with waits: sw r1,8(r0), then lw r6,8(r0), with mem_ready delayed 3 cycles per access. → Write request has addr 8, wdata 5, held stable across the waits. lw takes 5+3+3 = 11 cycles. r6 = 5.
- Control flow: beq r1,r1,+2 at pc 0x10 → next fetch at 0x1C. j 0x40 → next fetch at 0x100. Untaken beq → next fetch at pc+4.
- Trap: fetch opcode 111111. → halted = 1 two cycles after the fetch handshake; mem_req stays 0. Then assert reset → halted = 0 and pc = RESET_PC.
- Width: WIDTH = 64, addi r1,r0,-1. → r1 = 0xFFFFFFFFFFFFFFFF; add r2,r1,r1 → 0xFFFFFFFFFFFFFFFE.
